i2c_apb_scheduler: RTL
======================

# i2c_apb_scheduler

Two-requester scheduler that shares the APB-attached I2C master core between independent clients. It arbitrates round-robin and sequences each granted single-byte I2C transaction as a fixed series of APB register accesses: address, data, command, status poll and optional read-back. It returns completion, read data and error status to the winning requester. It sits between the client logic and the I2C core's APB slave port, and is the sole APB master on that port.

## Interface
Parameters:
- ADDR_REG, 8'h01, I2C core register: {slave_addr[6:0], rw}
- TX_REG, 8'h02, I2C core transmit data register
- RX_REG, 8'h03, I2C core receive data register
- CMD_REG, 8'h04, I2C core command register; writing 8'h01 starts a transfer
- STAT_REG, 8'h05, I2C core status register; bit0 = busy, bit1 = ack_err
- POLL_LIMIT, 255, maximum status reads per transaction before timeout (1..255)

Ports (clock and reset first):
- pclk  in  1  sole clock; all logic rising-edge
- preset  in  1  reset, synchronous, active-high
- req  in  2  per-requester request; held high until matching done bit
- req_addr0 / req_addr1  in  7  I2C slave address per requester
- req_rw  in  2  per-requester direction; 1 = read, 0 = write
- req_wdata0 / req_wdata1  in  8  write byte per requester
- gnt  out  2  one-hot; high for the whole granted transaction
- done  out  2  one-cycle completion pulse to the granted requester
- rdata  out  8  read byte; valid in the done cycle, held until next done
- err  out  2  valid with done: 00 ok, 01 ack_err, 10 poll timeout
- paddr  out  8  APB address
- pwdata  out  8  APB write data
- pwrite  out  1  APB direction
- pselx  out  1  APB select
- penable  out  1  APB enable
- prdata  in  8  APB read data
- pready  in  1  APB ready

## Operation
- States: IDLE, SETUP, ACCESS, DONE. Step register: ADDR, TX, CMD, POLL, READ.
- IDLE behaviour:
  - If any req bit is set, grant per round-robin. The last_gnt flag resets to 1, so requester 0 wins the first contention.
  - With both requesting, grant the requester that was not granted last. With one requesting, grant it.
  - On grant, latch addr/rw/wdata of the winner and clear the poll count. Step = ADDR, go to SETUP.
- SETUP: pselx=1, penable=0. Drive paddr/pwrite/pwdata for the current step:
  - ADDR: write {addr, rw}
  - TX: write wdata
  - CMD: write 8'h01
  - POLL: read STAT_REG
  - READ: read RX_REG
  - Always go to ACCESS.
- ACCESS: pselx=1, penable=1, with address and data held. Wait for pready, with no APB timeout. On pready, advance the step:
  - ADDR -> TX, except a read skips TX and goes ADDR -> CMD.
  - TX -> CMD.
  - CMD -> POLL.
  - POLL:
    - prdata[0]=1: increment the poll count. If the count reaches POLL_LIMIT, set err=10 and go to DONE; otherwise stay in POLL via SETUP.
    - prdata[0]=0 and prdata[1]=1: set err=01 and go to DONE, skipping READ.
    - prdata[0]=0 and prdata[1]=0: read goes to READ; write goes to DONE with err=00.
  - READ: capture prdata into rdata, set err=00, go to DONE.
  - Every non-DONE step transition returns to SETUP, so there are no idle cycles between transfers.
- DONE:
  - Drop pselx/penable.
  - Pulse done for the granted requester, with err valid.
  - Update last_gnt, clear gnt, return to IDLE. A new grant is possible in the next IDLE cycle.
- Requests:
  - A requester dropping req mid-transaction has no effect; the transaction completes and done still pulses.
  - Request fields are ignored after the grant cycle.
- Reset:
  - preset asserted at any point, including mid-APB-transfer, abandons the transaction.
  - Next cycle: state IDLE; all outputs 0 (gnt, done, rdata, err, paddr, pwdata, pwrite, pselx, penable); last_gnt=1; poll count 0.

## Timing
- req seen in IDLE at cycle N -> gnt and pselx high at N+1.
- Each APB transfer takes 2 cycles with pready=1, plus 1 per wait cycle. pselx stays continuously high across back-to-back transfers. penable is low for exactly 1 cycle at each transfer start.
- Latency with pready=1 and first poll not busy:
  - Write: ADDR, TX, CMD, POLL; done at N+9.
  - Read: ADDR, CMD, POLL, READ; done at N+9.
  - Each busy poll adds 2 cycles.
- Timeout: POLL_LIMIT busy reads occupy 2*POLL_LIMIT cycles in POLL.
- Back-to-back contention: second requester's pselx rises 2 cycles after the first's done (DONE -> IDLE -> SETUP).

## Test plan
- Write from req0, pready=1, status 8'h00: APB writes 0x01<-{0x50,0}=8'hA0, 0x02<-8'h3C, 0x04<-8'h01, then 1 read of 0x05. done[0] at N+9, err=00.
- Read from req1 at 0x50, status 8'h01 twice then 8'h00, RX returns 8'h5A: no TX write; 3 status reads; rdata=8'h5A, err=00, done[1] at N+13.
- Both req asserted from reset: req0 granted first, req1 granted on the cycle after done[0]. Repeat both held: grants alternate 0,1,0,1.
- Status 8'h02 on first poll: err=01 with done, no RX read, rdata unchanged.
- POLL_LIMIT=4, status stuck 8'h01: exactly 4 status reads, then err=10.
- pready low 3 cycles during TX access: paddr/pwdata stable, done delayed by 3 cycles. preset asserted during CMD access: all outputs 0 next cycle, no done pulse, and a subsequent request runs from ADDR.

Source files
------------

// File: rtl/i2c_apb_scheduler.sv
// Round-robin scheduler sharing an APB-attached I2C master between two
// clients; sequences one single-byte I2C transaction per grant.
module i2c_apb_scheduler #(
   parameter logic [7:0] ADDR_REG = 8'h01,
   parameter logic [7:0] TX_REG = 8'h02,
   parameter logic [7:0] RX_REG = 8'h03,
   parameter logic [7:0] CMD_REG = 8'h04,
   parameter logic [7:0] STAT_REG = 8'h05,
   parameter int POLL_LIMIT = 255
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic [1:0] req,
   input  logic [6:0] req_addr0,
   input  logic [6:0] req_addr1,
   input  logic [1:0] req_rw,
   input  logic [7:0] req_wdata0,
   input  logic [7:0] req_wdata1,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic [7:0] rdata,
   output logic [1:0] err,
   output logic [7:0] paddr,
   output logic [7:0] pwdata,
   output logic       pwrite,
   output logic       pselx,
   output logic       penable,
   input  logic [7:0] prdata,
   input  logic       pready
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] ST_ADDR = 3'd0;
   localparam logic [2:0] ST_TX = 3'd1;
   localparam logic [2:0] ST_CMD = 3'd2;
   localparam logic [2:0] ST_POLL = 3'd3;
   localparam logic [2:0] ST_READ = 3'd4;

   localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);

   logic [1:0] state;
   logic [2:0] step;
   logic       last_gnt;
   logic [6:0] lat_addr;
   logic       lat_rw;
   logic [7:0] lat_wdata;
   logic [7:0] poll_cnt;
   logic [7:0] poll_next;
   logic       win1;
   logic       apb_active;

   // requester 1 wins when alone, or when both ask and 0 went last
   assign win1 = req[1] & (~req[0] | ~last_gnt);
   assign poll_next = poll_cnt + 8'd1;
   assign apb_active = (state == S_SETUP) | (state == S_ACCESS);

   assign pselx = apb_active;
   assign penable = (state == S_ACCESS);
   assign done = (state == S_DONE) ? gnt : 2'b00;

   // APB address/data for the current step, zero outside a transfer
   always_comb begin
      paddr = '0;
      pwdata = '0;
      pwrite = 1'b0;
      if (apb_active) begin
         unique case (step)
            ST_ADDR: begin
               paddr = ADDR_REG;
               pwdata = {lat_addr, lat_rw};
               pwrite = 1'b1;
            end
            ST_TX: begin
               paddr = TX_REG;
               pwdata = lat_wdata;
               pwrite = 1'b1;
            end
            ST_CMD: begin
               paddr = CMD_REG;
               pwdata = 8'h01;
               pwrite = 1'b1;
            end
            ST_POLL: paddr = STAT_REG;
            ST_READ: paddr = RX_REG;
            default: paddr = '0;
         endcase
      end
   end

   // arbitration, APB sequencing and result capture
   always_ff @(posedge pclk) begin
      if (preset) begin
         state <= S_IDLE;
         step <= ST_ADDR;
         gnt <= 2'b00;
         last_gnt <= 1'b1;
         lat_addr <= '0;
         lat_rw <= 1'b0;
         lat_wdata <= '0;
         poll_cnt <= '0;
         rdata <= '0;
         err <= 2'b00;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (|req) begin
                  gnt <= win1 ? 2'b10 : 2'b01;
                  lat_addr <= win1 ? req_addr1 : req_addr0;
                  lat_rw <= win1 ? req_rw[1] : req_rw[0];
                  lat_wdata <= win1 ? req_wdata1 : req_wdata0;
                  poll_cnt <= '0;
                  step <= ST_ADDR;
                  state <= S_SETUP;
               end
            end
            S_SETUP: state <= S_ACCESS;
            S_ACCESS: begin
               if (pready) begin
                  state <= S_SETUP;
                  unique case (step)
                     ST_ADDR: step <= lat_rw ? ST_CMD : ST_TX;
                     ST_TX: step <= ST_CMD;
                     ST_CMD: step <= ST_POLL;
                     ST_POLL: begin
                        if (prdata[0]) begin
                           poll_cnt <= poll_next;
                           if (poll_next == LIMIT) begin
                              err <= 2'b10;
                              state <= S_DONE;
                           end
                        end else if (prdata[1]) begin
                           err <= 2'b01;
                           state <= S_DONE;
                        end else if (lat_rw) begin
                           step <= ST_READ;
                        end else begin
                           err <= 2'b00;
                           state <= S_DONE;
                        end
                     end
                     ST_READ: begin
                        rdata <= prdata;
                        err <= 2'b00;
                        state <= S_DONE;
                     end
                     default: state <= S_DONE;
                  endcase
               end
            end
            S_DONE: begin
               last_gnt <= gnt[1];
               gnt <= 2'b00;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
